gate_logic_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's single-bit two-input gates.
- Applies a selectable bitwise two-input function (AND, NAND, OR, NOR, XOR, XNOR) to WIDTH-bit operands.
- Two register stages with valid/ready handshake on both sides; full throughput of one operation per cycle.
- Sits between an operand producer and a result consumer that may apply backpressure.

---
 rtl/gate_logic_pipe.sv | 129 ++++++++++++
 tb/tb_gate_logic_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_logic_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : gate_logic_pipe
//  Purpose  : Two-stage valid/ready pipeline applying a selectable bitwise
//             two-input function (AND/NAND/OR/NOR/XOR/XNOR) to WIDTH-bit
//             operands. Optional macro GATE_LOGIC_PIPE_STATS_EN adds a
//             saturating 16-bit output-transfer counter (TXN_COUNT).
//  Revision : 1.0  initial release
// ============================================================================
module gate_logic_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] Y,
    output logic             Y_ALL1,
    output logic             Y_ERR,
    output logic             OUT_VALID,
    input  logic             OUT_READY
`ifdef GATE_LOGIC_PIPE_STATS_EN
    ,
    output logic [15:0]      TXN_COUNT
`endif
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_y;
    logic             s2_all1;
    logic             s2_err;

    logic             s2_adv;
    logic             s1_adv;
    logic             in_xfer;

    logic [WIDTH-1:0] func_y;
    logic             func_err;
    logic             func_all1;

    assign s2_adv  = !s2_valid || OUT_READY;
    assign s1_adv  = !s1_valid || s2_adv;
    assign in_xfer = IN_VALID && s1_adv;

    always_comb begin
        func_y   = '0;
        func_err = 1'b0;
        case (s1_op)
            OP_AND:  func_y = s1_a & s1_b;
            OP_NAND: func_y = ~(s1_a & s1_b);
            OP_OR:   func_y = s1_a | s1_b;
            OP_NOR:  func_y = ~(s1_a | s1_b);
            OP_XOR:  func_y = s1_a ^ s1_b;
            OP_XNOR: func_y = ~(s1_a ^ s1_b);
            default: func_err = 1'b1;
        endcase
    end

    // Illegal ops force func_y to zero, so the reduction is already 0 for them.
    assign func_all1 = &func_y;

    // Operand registers load only on a real transfer, so idle-cycle X never enters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            s2_valid <= 1'b0;
            s2_y     <= '0;
            s2_all1  <= 1'b0;
            s2_err   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_xfer;
                if (in_xfer) begin
                    s1_a  <= A;
                    s1_b  <= B;
                    s1_op <= OP;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_y    <= func_y;
                    s2_all1 <= func_all1;
                    s2_err  <= func_err;
                end
            end
        end
    end

    assign IN_READY  = s1_adv;
    assign OUT_VALID = s2_valid;
    assign Y         = s2_y;
    assign Y_ALL1    = s2_all1;
    assign Y_ERR     = s2_err;

`ifdef GATE_LOGIC_PIPE_STATS_EN
    logic [15:0] txn_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            txn_count <= 16'd0;
        end else if (s2_valid && OUT_READY && (txn_count != 16'hFFFF)) begin
            txn_count <= txn_count + 16'd1;
        end
    end

    assign TXN_COUNT = txn_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_logic_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gate_logic_pipe
//  Purpose  : Self-checking bench for gate_logic_pipe (WIDTH=8 and WIDTH=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_gate_logic_pipe;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic [7:0] a, b, y;
    logic [2:0] op;
    logic       in_valid, in_ready, y_all1, y_err, out_valid, out_ready;

    logic [0:0] a1, b1, y1;
    logic [2:0] op1;
    logic       in_valid1, in_ready1, all1_1, err1, out_valid1, out_ready1;

`ifdef GATE_LOGIC_PIPE_STATS_EN
    logic [15:0] txn8, txn1;
`endif

    gate_logic_pipe #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst), .A(a), .B(b), .OP(op),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .Y(y), .Y_ALL1(y_all1), .Y_ERR(y_err),
        .OUT_VALID(out_valid), .OUT_READY(out_ready)
`ifdef GATE_LOGIC_PIPE_STATS_EN
        , .TXN_COUNT(txn8)
`endif
    );

    gate_logic_pipe #(.WIDTH(1)) dut1 (
        .CLK(clk), .RST(rst), .A(a1), .B(b1), .OP(op1),
        .IN_VALID(in_valid1), .IN_READY(in_ready1),
        .Y(y1), .Y_ALL1(all1_1), .Y_ERR(err1),
        .OUT_VALID(out_valid1), .OUT_READY(out_ready1)
`ifdef GATE_LOGIC_PIPE_STATS_EN
        , .TXN_COUNT(txn1)
`endif
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [7:0] y;
        logic       all1;
        logic       err;
    } res_t;

    // Reference: each result bit decided by how many of the two input bits are 1.
    function automatic res_t model(input logic [7:0] aa, input logic [7:0] bb, input logic [2:0] o);
        res_t r;
        r.y   = 8'h00;
        r.err = (o > 3'd5);
        for (int i = 0; i < 8; i++) begin
            int  ones;
            logic v;
            ones = int'(aa[i]) + int'(bb[i]);
            case (o)
                3'd0:    v = (ones == 2);
                3'd1:    v = (ones != 2);
                3'd2:    v = (ones >= 1);
                3'd3:    v = (ones == 0);
                3'd4:    v = (ones == 1);
                3'd5:    v = (ones != 1);
                default: v = 1'b0;
            endcase
            r.y[i] = v;
        end
        r.all1 = (r.y == 8'hFF);
        return r;
    endfunction

    // Scoreboard: transfers observed just before the edge on which they happen.
    res_t q[$];
    int   acc_cnt = 0;
    int   out_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                out_cnt++;
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL sb_unexpected: got output y=%0h with no operand outstanding", y);
                end else begin
                    res_t e;
                    e = q.pop_front();
                    chk("sb_y", y, e.y);
                    chk("sb_all1", y_all1, e.all1);
                    chk("sb_err", y_err, e.err);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, op));
                acc_cnt++;
            end
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] y;
        logic       all1;
        logic       err;
    } vec_t;

    typedef struct {
        logic [0:0] a;
        logic [0:0] b;
        logic [0:0] y;
    } vec1_t;

    vec_t  tv[10];
    vec1_t tv1[4];
    vec_t  bp[3];

    initial begin
        int         base, ob, idx, cyc;
        logic [7:0] ysnap;

        tv[0] = '{8'hF0, 8'hCC, 3'd0, 8'hC0, 1'b0, 1'b0};
        tv[1] = '{8'hF0, 8'hCC, 3'd1, 8'h3F, 1'b0, 1'b0};
        tv[2] = '{8'hF0, 8'hCC, 3'd2, 8'hFC, 1'b0, 1'b0};
        tv[3] = '{8'hF0, 8'hCC, 3'd3, 8'h03, 1'b0, 1'b0};
        tv[4] = '{8'hF0, 8'hCC, 3'd4, 8'h3C, 1'b0, 1'b0};
        tv[5] = '{8'hF0, 8'hCC, 3'd5, 8'hC3, 1'b0, 1'b0};
        tv[6] = '{8'hFF, 8'hFF, 3'd0, 8'hFF, 1'b1, 1'b0};
        tv[7] = '{8'hFF, 8'hFF, 3'd6, 8'h00, 1'b0, 1'b1};
        tv[8] = '{8'h00, 8'h00, 3'd3, 8'hFF, 1'b1, 1'b0};
        tv[9] = '{8'hAA, 8'h55, 3'd7, 8'h00, 1'b0, 1'b1};
        tv1[0] = '{1'b0, 1'b0, 1'b1};
        tv1[1] = '{1'b0, 1'b1, 1'b1};
        tv1[2] = '{1'b1, 1'b0, 1'b1};
        tv1[3] = '{1'b1, 1'b1, 1'b0};
        bp[0] = '{8'h12, 8'h34, 3'd2, 8'h00, 1'b0, 1'b0};
        bp[1] = '{8'h56, 8'h78, 3'd4, 8'h00, 1'b0, 1'b0};
        bp[2] = '{8'h9A, 8'hBC, 3'd1, 8'h00, 1'b0, 1'b0};

        // Reset held two cycles with operands offered
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        a = 8'h5A; b = 8'h3C; op = 3'd2;
        a1 = 1'b1; b1 = 1'b1; op1 = 3'd0; in_valid1 = 1'b1; out_ready1 = 1'b1;
        step(); step();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_y", y, 0);
        chk("reset_y_all1", y_all1, 0);
        chk("reset_y_err", y_err, 0);
        chk("reset_in_ready", in_ready, 1);
        rst = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
        step(); step(); step();
        chk("reset_no_result", out_cnt, 0);
        chk("reset_idle_out_valid", out_valid, 0);

        // Truth table, WIDTH=8
        for (int j = 0; j <= 10; j++) begin
            if (j < 10) begin
                a = tv[j].a; b = tv[j].b; op = tv[j].op; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (j == 0) begin
                chk("latency_not_yet", out_valid, 0);
            end else begin
                chk($sformatf("tt%0d_valid", j - 1), out_valid, 1);
                chk($sformatf("tt%0d_y", j - 1), y, tv[j - 1].y);
                chk($sformatf("tt%0d_all1", j - 1), y_all1, tv[j - 1].all1);
                chk($sformatf("tt%0d_err", j - 1), y_err, tv[j - 1].err);
            end
        end
        step();

        // Truth table, WIDTH=1, NAND
        for (int j = 0; j <= 4; j++) begin
            if (j < 4) begin
                a1 = tv1[j].a; b1 = tv1[j].b; op1 = 3'd1; in_valid1 = 1'b1;
            end else begin
                in_valid1 = 1'b0;
            end
            step();
            if (j > 0) begin
                chk($sformatf("w1_%0d_valid", j - 1), out_valid1, 1);
                chk($sformatf("w1_%0d_y", j - 1), y1, tv1[j - 1].y);
                chk($sformatf("w1_%0d_all1", j - 1), all1_1, tv1[j - 1].y);
                chk($sformatf("w1_%0d_err", j - 1), err1, 0);
            end
        end
        step();

        // Backpressure: only two ops fit while the consumer stalls
        base = acc_cnt; ob = out_cnt; ysnap = 8'h00;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            idx = acc_cnt - base;
            if (idx > 2) idx = 2;
            a = bp[idx].a; b = bp[idx].b; op = bp[idx].op;
            step();
            if (c == 2) ysnap = y;
        end
        chk("bp_accepted", acc_cnt - base, 2);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_y_stable", y, ysnap);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_rise", in_ready, 1);
        cyc = 0;
        while ((out_cnt - ob) < 3 && cyc < 12) begin
            idx = acc_cnt - base;
            if (idx < 3) begin
                a = bp[idx].a; b = bp[idx].b; op = bp[idx].op; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        step(); step();
        chk("bp_results", out_cnt - ob, 3);
        chk("bp_accepted_total", acc_cnt - base, 3);

        // Random traffic with random stalls
        base = acc_cnt; cyc = 0;
        while ((acc_cnt - base) < 1000 && cyc < 20000) begin
            in_valid  = ($urandom % 2) == 1;
            a         = 8'($urandom);
            b         = 8'($urandom);
            op        = 3'($urandom_range(0, 7));
            out_ready = ($urandom % 2) == 1;
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 10) begin
            step();
            cyc++;
        end
        chk("rand_accepted", (acc_cnt - base) >= 1000, 1);
        chk("rand_drained", q.size(), 0);

        // Reset with two ops in flight
        out_ready = 1'b0; in_valid = 1'b1;
        a = 8'hC3; b = 8'h0F; op = 3'd4;
        step();
        a = 8'h77; b = 8'h11; op = 3'd0;
        step();
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b1; ob = out_cnt;
        step(); step(); step();
        chk("mid_rst_no_output", out_cnt - ob, 0);
        chk("mid_rst_out_valid", out_valid, 0);
`ifdef GATE_LOGIC_PIPE_STATS_EN
        chk("txn_cleared", txn8, 0);
        chk("txn1_cleared", txn1, 0);
`endif
        a = 8'h3C; b = 8'hA5; op = 3'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("mid_rst_next_valid", out_valid, 1);
        chk("mid_rst_next_y", y, 8'h66);
        step();
        chk("mid_rst_next_count", out_cnt - ob, 1);
`ifdef GATE_LOGIC_PIPE_STATS_EN
        chk("txn_one", txn8, 1);
`endif
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
